// File: rtl/error_accumulator.sv
// error_accumulator: scores an approximate multiplier over a run of DEPTH
// product beats. Each accepted beat is compared against the exact product.
// The run reports three statistics of |exact - approx|: a saturating sum,
// the maximum, and the count of beats whose error is nonzero.
module error_accumulator #(
  parameter int DEPTH = 16,
  parameter int SUMW  = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [7:0]      in_a,
  input  logic [7:0]      in_b,
  input  logic [15:0]     in_p,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [SUMW-1:0] err_sum,
  output logic [15:0]     err_max,
  output logic [4:0]      err_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, DRAIN, REPORT} state_t;

  localparam logic [4:0] LAST_BEAT = 5'(DEPTH - 1);

  state_t        state, state_next;
  logic [4:0]    beat_cnt;
  logic          s1_valid;
  logic [15:0]   s1_exact;
  logic [15:0]   s1_p;
  logic          accept;
  logic [15:0]   err;
  logic [SUMW:0] sum_wide;

  assign ready  = (state == COLLECT);
  assign busy   = (state != IDLE);
  assign done   = (state == REPORT);
  assign accept = ready & in_valid;

  // Next-state logic for the run sequencer
  always_comb begin
    // NOTE: state_next is assigned a default first so that no path through
    // the case leaves it unassigned, which would infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CLEAR;
      CLEAR:   state_next = COLLECT;
      COLLECT: if (accept && beat_cnt == LAST_BEAT) state_next = DRAIN;
      DRAIN:   state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; reset wins over every other input
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of the order blocks are evaluated.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Absolute error of the beat held in stage 1, and the widened sum used
  // to detect overflow before saturating
  always_comb begin
    err      = (s1_exact >= s1_p) ? (s1_exact - s1_p) : (s1_p - s1_exact);
    sum_wide = {1'b0, err_sum} + (SUMW + 1)'(err);
  end

  // Beat counter and stage-1 valid bit
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) beat_cnt <= beat_cnt + 5'd1;
    end
  end

  // Stage-1 data registers, qualified by s1_valid
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers carry no reset; nothing reads them
    // unless s1_valid, which is itself reset.
    if (accept) begin
      s1_exact <= 16'(in_a) * 16'(in_b);
      s1_p     <= in_p;
    end
  end

  // Error statistics: cleared at the start of a run, updated one edge after
  // each stage-1 beat, and otherwise held so results stay stable after REPORT
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      err_sum <= '0;
      err_max <= '0;
      err_cnt <= '0;
    end else if (s1_valid) begin
      err_sum <= sum_wide[SUMW] ? {SUMW{1'b1}} : sum_wide[SUMW-1:0];
      if (err > err_max) err_max <= err;
      if (err != 16'd0)  err_cnt <= err_cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_error_accumulator.sv
// Directed bench for error_accumulator. Two instances share one stimulus
// stream: a default 24-bit accumulator and a 16-bit one that can saturate.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_error_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] in_p;

  logic        ready, busy, done;
  logic [23:0] err_sum;
  logic [15:0] err_max;
  logic [4:0]  err_cnt;

  logic        ready16, busy16, done16;
  logic [15:0] err_sum16;
  logic [15:0] err_max16;
  logic [4:0]  err_cnt16;

  int vectors    = 0;
  int miscompares = 0;
  int done_seen  = 0;
  int runs_done  = 0;

  error_accumulator #(.DEPTH(16), .SUMW(24)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .ready(ready), .busy(busy), .done(done),
    .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt)
  );

  error_accumulator #(.DEPTH(16), .SUMW(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_p(in_p),
    .ready(ready16), .busy(busy16), .done(done16),
    .err_sum(err_sum16), .err_max(err_max16), .err_cnt(err_cnt16)
  );

  always #5 clk = ~clk;

  // Count done pulses as the design presents them at each rising edge
  always @(posedge clk) if (done) done_seen <= done_seen + 1;

  // Start a run; optionally keep start high and present an unaccepted
  // garbage beat while ready is low
  task automatic start_run(input string name, input bit hold);
    start = 1'b1;
    if (hold) begin
      in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_p = 16'd0;
    end
    @(negedge clk);
    if (!hold) start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s clear: busy=%b ready=%b want busy=1 ready=0", name, busy, ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s collect ready: got %b want 1", name, ready);
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded wait)
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int w = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_p = p;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL beat timeout: ready got %b want 1", ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // n beats whose approximate product is exact; gap idle cycles after each
  task automatic exact_beats(input int n, input int seed, input int gap);
    logic [7:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = 8'(i * 13 + seed);
      b = 8'(i * 29 + 7);
      beat(a, b, 16'(a) * 16'(b));
      repeat (gap) @(negedge clk);
    end
  endtask

  // Called at the falling edge right after the last accept: expects one
  // DRAIN cycle, then REPORT with done and final results, then IDLE
  task automatic finish_run(input string name, input logic [23:0] sum24,
                            input logic [15:0] sum16, input logic [15:0] mx,
                            input logic [4:0] cnt);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL %s drain: done=%b busy=%b ready=%b want 0 1 0", name, done, busy, ready);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || done16 !== 1'b1) begin
      miscompares++;
      $display("FAIL %s report done: got %b/%b want 1/1", name, done, done16);
    end
    vectors++;
    if (err_sum !== sum24 || err_max !== mx || err_cnt !== cnt) begin
      miscompares++;
      $display("FAIL %s results: sum=%0d max=%0d cnt=%0d want %0d %0d %0d",
               name, err_sum, err_max, err_cnt, sum24, mx, cnt);
    end
    vectors++;
    if (err_sum16 !== sum16 || err_max16 !== mx || err_cnt16 !== cnt) begin
      miscompares++;
      $display("FAIL %s results16: sum=%0d max=%0d cnt=%0d want %0d %0d %0d",
               name, err_sum16, err_max16, err_cnt16, sum16, mx, cnt);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || err_sum !== sum24 || err_max !== mx || err_cnt !== cnt) begin
      miscompares++;
      $display("FAIL %s idle hold: done=%b busy=%b sum=%0d max=%0d cnt=%0d want 0 0 %0d %0d %0d",
               name, done, busy, err_sum, err_max, err_cnt, sum24, mx, cnt);
    end
    runs_done++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_p = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err_sum !== 24'd0 || err_max !== 16'd0 || err_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL reset: ready=%b busy=%b done=%b sum=%0d max=%0d cnt=%0d want all 0",
               ready, busy, done, err_sum, err_max, err_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle without start: busy got %b want 0", busy);
    end
  endtask

  task automatic test_exact();
    start_run("exact", 1'b0);
    exact_beats(16, 1, 0);
    finish_run("exact", 24'd0, 16'd0, 16'd0, 5'd0);
  endtask

  // Runs back-to-back with test_exact: start issued from the first IDLE cycle
  task automatic test_back_to_back();
    start_run("off_by_one", 1'b0);
    for (int i = 0; i < 16; i++) beat(8'd255, 8'd255, 16'hFE00);
    finish_run("off_by_one", 24'd16, 16'd16, 16'd1, 5'd16);
  endtask

  task automatic test_mixed();
    start_run("mixed", 1'b0);
    beat(8'd3, 8'd5, 16'd16);
    beat(8'd200, 8'd200, 16'h9000);
    exact_beats(14, 40, 0);
    finish_run("mixed", 24'd3137, 16'd3137, 16'd3136, 5'd2);
  endtask

  // 16 * 65025 = 1040400 fits 24 bits but saturates a 16-bit sum
  task automatic test_saturate();
    start_run("saturate", 1'b0);
    for (int i = 0; i < 16; i++) beat(8'd255, 8'd255, 16'd0);
    finish_run("saturate", 24'd1040400, 16'hFFFF, 16'd65025, 5'd16);
  endtask

  task automatic test_reset_mid_run();
    start_run("abort", 1'b0);
    for (int i = 0; i < 5; i++) beat(8'd255, 8'd255, 16'd0);
    vectors++;
    if (err_sum !== 24'd260100 || err_cnt !== 5'd4) begin
      miscompares++;
      $display("FAIL abort partial: sum=%0d cnt=%0d want 260100 4", err_sum, err_cnt);
    end
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err_sum !== 24'd0 || err_max !== 16'd0 || err_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL abort reset: ready=%b busy=%b done=%b sum=%0d max=%0d cnt=%0d want all 0",
               ready, busy, done, err_sum, err_max, err_cnt);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort stays idle: busy got %b want 0", busy);
    end
    start_run("after_abort", 1'b0);
    exact_beats(16, 77, 0);
    finish_run("after_abort", 24'd0, 16'd0, 16'd0, 5'd0);
  endtask

  task automatic test_start_held_gaps();
    start_run("held", 1'b1);
    beat(8'd3, 8'd5, 16'd16);
    repeat (2) @(negedge clk);
    vectors++;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL held gap: ready=%b busy=%b want 1 1", ready, busy);
    end
    exact_beats(14, 9, 1);
    beat(8'd12, 8'd12, 16'd144);
    // Now in DRAIN: drop start, push an ignored garbage beat
    start = 1'b0;
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_p = 16'd0;
    finish_run("held", 24'd1, 16'd1, 16'd1, 5'd1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || err_sum !== 24'd1) begin
      miscompares++;
      $display("FAIL held no restart: busy=%b sum=%0d want 0 1", busy, err_sum);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_back_to_back();
    test_mixed();
    test_saturate();
    test_reset_mid_run();
    test_start_held_gaps();
    @(negedge clk);
    vectors++;
    if (done_seen !== runs_done) begin
      miscompares++;
      $display("FAIL done pulse count: got %0d want %0d", done_seen, runs_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
